// File: rtl/universal_shift_register.sv
// WIDTH-bit register with parallel load and multi-step logical, rotate and arithmetic
// shifts in either direction. Commands use a start/busy/done handshake.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             ser_in_lsb,
  input  logic             ser_in_msb,
  output logic [WIDTH-1:0] parallel_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHRL = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;
  localparam logic [2:0] MODE_SHRA = 3'd6;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_next;
  logic [AMT_W-1:0] count, count_next;
  logic [2:0]       op, op_next;
  logic [WIDTH-1:0] data_next;
  logic             ser_next, busy_next, done_next;
  logic [WIDTH:0]   step_result;
  logic             is_shift;

  // One step of the latched operation; returns {expelled bit, new word}.
  function automatic logic [WIDTH:0] shift_step(input logic [2:0]       sel,
                                                input logic [WIDTH-1:0] q,
                                                input logic             ser,
                                                input logic             lsb_in,
                                                input logic             msb_in);
    logic [WIDTH:0] r;
    r = {ser, q};
    case (sel)
      MODE_SHL:  r = {q[WIDTH-1], q[WIDTH-2:0], lsb_in};
      MODE_SHRL: r = {q[0], msb_in, q[WIDTH-1:1]};
      MODE_ROL:  r = {q[WIDTH-1], q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  r = {q[0], q[0], q[WIDTH-1:1]};
      MODE_SHRA: r = {q[0], q[WIDTH-1], q[WIDTH-1:1]};
      default:   r = {ser, q};
    endcase
    return r;
  endfunction

  assign is_shift    = (mode >= MODE_SHL) && (mode <= MODE_SHRA);
  assign step_result = shift_step(op, parallel_out, ser_out, ser_in_lsb, ser_in_msb);

  always_comb begin
    state_next = state;
    count_next = count;
    op_next    = op;
    data_next  = parallel_out;
    ser_next   = ser_out;
    busy_next  = busy;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (mode == MODE_LOAD) begin
            data_next = parallel_in;
            done_next = 1'b1;
          end else if (is_shift && (amount != '0)) begin
            op_next    = mode;
            count_next = amount;
            busy_next  = 1'b1;
            state_next = SHIFT;
          end else begin
            // hold, reserved, or zero-length shift: acknowledge only
            done_next = 1'b1;
          end
        end
      end
      SHIFT: begin
        data_next  = step_result[WIDTH-1:0];
        ser_next   = step_result[WIDTH];
        count_next = count - AMT_W'(1);
        if (count == AMT_W'(1)) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      op           <= MODE_HOLD;
      parallel_out <= '0;
      ser_out      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      op           <= op_next;
      parallel_out <= data_next;
      ser_out      <= ser_next;
      busy         <= busy_next;
      done         <= done_next;
    end
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register (WIDTH=8, AMT_W=4): behavioural model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_universal_shift_register;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start, ser_in_lsb, ser_in_msb;
  logic [2:0] mode;
  logic [3:0] amount;
  logic [7:0] parallel_in, parallel_out;
  logic       ser_out, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int m_q = 0, m_ser = 0, m_busy = 0, m_done = 0, m_left = 0, m_mode = 0;
  int bc;
  bit gd;
  logic [7:0] trace[$];

  universal_shift_register #(.WIDTH(8), .AMT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .amount(amount),
    .parallel_in(parallel_in), .ser_in_lsb(ser_in_lsb), .ser_in_msb(ser_in_msb),
    .parallel_out(parallel_out), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining-step count plus integer arithmetic on the word.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q = 0; m_ser = 0; m_busy = 0; m_done = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        case (m_mode)
          2: begin m_ser = (m_q >> 7) & 1; m_q = ((m_q << 1) | int'(ser_in_lsb)) & 255; end
          3: begin m_ser = m_q & 1; m_q = (m_q >> 1) | (int'(ser_in_msb) << 7); end
          4: begin m_ser = (m_q >> 7) & 1; m_q = ((m_q << 1) | (m_q >> 7)) & 255; end
          5: begin m_ser = m_q & 1; m_q = (m_q >> 1) | ((m_q & 1) << 7); end
          default: begin m_ser = m_q & 1; m_q = (m_q >> 1) | (m_q & 128); end
        endcase
        m_left--;
        if (m_left == 0) begin m_busy = 0; m_done = 1; end
      end else if (start) begin
        if (mode == 3'd1) begin
          m_q = int'(parallel_in); m_done = 1;
        end else if (mode >= 3'd2 && mode <= 3'd6 && amount != 4'd0) begin
          m_left = int'(amount); m_mode = int'(mode); m_busy = 1;
        end else begin
          m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_parallel_out", int'(parallel_out), m_q);
    check("cyc_ser_out", int'(ser_out), m_ser);
    check("cyc_busy", int'(busy), m_busy);
    check("cyc_done", int'(done), m_done);
  end

  // Issue one command and wait (bounded) for its done pulse.
  task automatic run_cmd(input logic [2:0] m, input logic [3:0] a, input logic [7:0] p,
                         output int busy_cyc, output bit got_done);
    @(negedge clk);
    start = 1'b1; mode = m; amount = a; parallel_in = p;
    @(negedge clk);
    start = 1'b0;
    busy_cyc = 0; got_done = 1'b0;
    trace.delete();
    for (int i = 0; i < 40; i++) begin
      if (busy) begin busy_cyc++; trace.push_back(parallel_out); end
      if (done) begin got_done = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    start = 0; mode = 0; amount = 0; parallel_in = 0; ser_in_lsb = 0; ser_in_msb = 0;
    #1 reset = 1'b1;
    #11;
    check("rst_parallel_out", int'(parallel_out), 0);
    check("rst_ser_out", int'(ser_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;

    run_cmd(3'd1, 4'd0, 8'hA5, bc, gd);
    check("load_done", int'(gd), 1);
    check("load_value", int'(parallel_out), 'hA5);
    check("load_model", m_q, 'hA5);
    check("load_busy_cycles", bc, 0);
    @(negedge clk);
    check("load_done_falls", int'(done), 0);

    ser_in_lsb = 1'b1;
    run_cmd(3'd2, 4'd3, 8'h00, bc, gd);
    check("shl_done", int'(gd), 1);
    check("shl_step1", (trace.size() > 1) ? int'(trace[1]) : -1, 'h4B);
    check("shl_step2", (trace.size() > 2) ? int'(trace[2]) : -1, 'h97);
    check("shl_final", int'(parallel_out), 'h2F);
    check("shl_model", m_q, 'h2F);
    check("shl_ser_out", int'(ser_out), 1);
    check("shl_busy_cycles", bc, 3);

    run_cmd(3'd1, 4'd0, 8'h81, bc, gd);
    run_cmd(3'd5, 4'd1, 8'h00, bc, gd);
    check("ror1_value", int'(parallel_out), 'hC0);
    check("ror1_busy_cycles", bc, 1);

    run_cmd(3'd1, 4'd0, 8'h81, bc, gd);
    run_cmd(3'd5, 4'd8, 8'h00, bc, gd);
    check("ror8_value", int'(parallel_out), 'h81);
    check("ror8_busy_cycles", bc, 8);

    run_cmd(3'd1, 4'd0, 8'h90, bc, gd);
    run_cmd(3'd6, 4'd2, 8'h00, bc, gd);
    check("sra2_value", int'(parallel_out), 'hE4);
    check("sra2_model", m_q, 'hE4);

    run_cmd(3'd1, 4'd0, 8'h90, bc, gd);
    ser_in_msb = 1'b0;
    run_cmd(3'd3, 4'd2, 8'h00, bc, gd);
    check("srl2_value", int'(parallel_out), 'h24);
    check("srl2_ser_out", int'(ser_out), 0);

    // 5-step shift left from 0x24 with a load request injected mid-command
    ser_in_lsb = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 3'd2; amount = 4'd5;
    @(negedge clk);
    start = 1'b1; mode = 3'd1; parallel_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    gd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin gd = 1'b1; break; end
      @(negedge clk);
    end
    check("ignore_start_done", int'(gd), 1);
    check("ignore_start_value", int'(parallel_out), 'h80);

    run_cmd(3'd2, 4'd0, 8'h00, bc, gd);
    check("amt0_done", int'(gd), 1);
    check("amt0_busy_cycles", bc, 0);
    check("amt0_unchanged", int'(parallel_out), 'h80);
    run_cmd(3'd0, 4'd3, 8'h11, bc, gd);
    check("hold_done", int'(gd), 1);
    check("hold_unchanged", int'(parallel_out), 'h80);
    run_cmd(3'd7, 4'd3, 8'h22, bc, gd);
    check("rsvd_busy_cycles", bc, 0);
    check("rsvd_unchanged", int'(parallel_out), 'h80);

    // Reset asserted between edges of a 10-step rotate of 0xFF
    run_cmd(3'd1, 4'd0, 8'hFF, bc, gd);
    @(negedge clk);
    start = 1'b1; mode = 3'd4; amount = 4'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_ser_out", int'(ser_out), 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_parallel_out", int'(parallel_out), 0);
    check("midrst_ser_out", int'(ser_out), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    run_cmd(3'd1, 4'd0, 8'h3C, bc, gd);
    check("post_rst_load_done", int'(gd), 1);
    check("post_rst_load_value", int'(parallel_out), 'h3C);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised successor to the 4-bit parallel-in/parallel-out shift register. It holds a WIDTH-bit word and supports parallel load plus logical, rotate and arithmetic shifts in either direction. Each shift command runs for a programmable number of steps under a start/busy/done handshake. It sits between parallel datapath logic and bit-serial links, and is used both as a PIPO staging register and as a multi-bit serialiser/deserialiser.

## Interface
- WIDTH, 8: register width in bits (≥2).
- AMT_W, 4: width of the step-count input; max steps per command = 2^AMT_W − 1.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  command request; sampled only in IDLE.
- mode  in  3  command: 000 hold, 001 load, 010 shift left, 011 shift right logical, 100 rotate left, 101 rotate right, 110 shift right arithmetic, 111 reserved.
- amount  in  AMT_W  number of shift steps for shift/rotate modes.
- parallel_in  in  WIDTH  load data.
- ser_in_lsb  in  1  bit entering bit 0 on shift left.
- ser_in_msb  in  1  bit entering bit WIDTH−1 on logical shift right.
- parallel_out  out  WIDTH  register contents.
- ser_out  out  1  bit expelled by the most recent shift/rotate step.
- busy  out  1  multi-step command in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SHIFT. The state, step counter and latched mode are internal registers.
- IDLE, start=0: nothing changes.
- IDLE, start=1, mode=load: parallel_out<=parallel_in and done<=1. The FSM stays in IDLE and busy stays 0.
- IDLE, start=1, mode hold or 111, or a shift/rotate mode with amount=0: no data change; done<=1, busy stays 0.
- IDLE, start=1, shift/rotate mode with amount=N≥1: latch mode, counter<=N, busy<=1, go to SHIFT. No data step occurs on the acceptance edge.
- SHIFT: one step per edge and the counter decrements. On the edge where the counter goes 1→0, the FSM returns to IDLE, busy<=0 and done<=1.
- Steps:
  - Shift left: {q[W−2:0], ser_in_lsb}; ser_out<=q[W−1].
  - Shift right logical: {ser_in_msb, q[W−1:1]}; ser_out<=q[0].
  - Rotate left: {q[W−2:0], q[W−1]}; ser_out<=q[W−1].
  - Rotate right: {q[0], q[W−1:1]}; ser_out<=q[0].
  - Arithmetic right: {q[W−1], q[W−1:1]}; ser_out<=q[0].
- ser_in_lsb and ser_in_msb are sampled live at every step. mode and amount are used only at acceptance. parallel_in is used only for load.
- start in SHIFT is ignored entirely: no queueing, no effect on the counter.
- ser_out holds its value between steps and is unaffected by load.
- Reset, including mid-command: parallel_out=0, ser_out=0, busy=0, done=0, state IDLE, counter 0. The first start after reset deasserts is accepted normally.

## Timing
- Load / no-op: command accepted at edge k; done high for the single cycle after edge k.
- Shift N: accepted at edge k (busy rises); steps at edges k+1..k+N; busy falls and done rises at edge k+N; done falls at edge k+N+1. Latency is N+1 edges.
- A new start may be accepted at edge k+N+1, back-to-back with the done cycle.
- All outputs are registered, with no combinational input→output paths.

## Test plan
All scenarios use WIDTH=8, AMT_W=4.
- Reset, then load 0xA5 -> parallel_out=0xA5 after one edge; done high exactly 1 cycle; busy stays 0.
- From 0xA5, shift left amount=3 with ser_in_lsb=1 -> intermediate 0x4B, 0x97, final 0x2F; ser_out=1; busy high 3 cycles; done at edge k+3.
- Load 0x81, rotate right amount=1 -> 0xC0. Rotate right amount=8 from 0x81 -> 0x81, busy 8 cycles.
- Load 0x90, arithmetic right amount=2 -> 0xE4. Reload 0x90, logical right amount=2 with ser_in_msb=0 -> 0x24, ser_out=0.
- During a 5-step shift, pulse start with mode=load, parallel_in=0xFF -> ignored and the shift completes normally. A shift with amount=0 -> done pulse, parallel_out unchanged.
- Assert reset mid-way through a 10-step rotate -> parallel_out, ser_out, busy and done go to 0 immediately. After release, load 0x3C succeeds.
